// File: rtl/meteor_rand_pkg.sv
// rtl/meteor_rand_pkg.sv - Shared types, constants and LFSR tap function for the meteor random arbiter
package meteor_rand_pkg;

  typedef enum logic [0:0] {WARM, RUN} rand_state_t;

  localparam logic [15:0] LFSR_RESET_VAL = 16'h0001;

  // Fibonacci feedback for a right-shifting LFSR; state is zero-extended to 16 bits.
  function automatic logic lfsr_fb(input int width, input logic [15:0] state);
    if (width == 8) begin
      return state[0] ^ state[4] ^ state[5] ^ state[6];
    end else begin
      return state[0] ^ state[2] ^ state[3] ^ state[5];
    end
  endfunction

endpackage

// File: rtl/meteor_rand_arbiter_lfsr_core.sv
// rtl/meteor_rand_arbiter_lfsr_core.sv - LFSR state register with seed load, zero-seed guard and step enable
module rand_lfsr_core #(
  parameter int LFSR_W = 16,
  parameter int OUT_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [OUT_W-1:0]  o_value
);
  import meteor_rand_pkg::*;

  logic [LFSR_W-1:0] r_state;
  logic              w_fb;

  assign w_fb    = lfsr_fb(LFSR_W, 16'(r_state));
  assign o_value = r_state[OUT_W-1:0];

  // An all-zero state would lock the LFSR, so a zero seed is replaced by the reset value.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= LFSR_W'(LFSR_RESET_VAL);
    end else if (i_load) begin
      r_state <= (i_seed == '0) ? LFSR_W'(LFSR_RESET_VAL) : i_seed;
    end else if (i_step) begin
      r_state <= {w_fb, r_state[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/meteor_rand_arbiter.sv
// rtl/meteor_rand_arbiter.sv - Round-robin arbiter handing out shared LFSR values to N_REQ clients
module meteor_rand_arbiter #(
  parameter int N_REQ  = 4,
  parameter int LFSR_W = 16,
  parameter int OUT_W  = 10,
  parameter int WARMUP = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic [N_REQ-1:0]  i_req,
  output logic [N_REQ-1:0]  o_gnt,
  output logic [OUT_W-1:0]  o_rdata,
  output logic              o_ready
);
  import meteor_rand_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  rand_state_t      r_fsm;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [OUT_W-1:0] r_rdata;
  logic             r_ready;

  logic [OUT_W-1:0] w_value;
  logic             w_step;
  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_rot;
  logic             w_found;
  logic [PTR_W-1:0] w_off;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_ptr_next;

  // The LFSR free-runs in both WARM and RUN; only a seed load freezes it for a cycle.
  assign w_step = !i_seed_load;

  rand_lfsr_core #(
    .LFSR_W (LFSR_W),
    .OUT_W  (OUT_W)
  ) u_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (i_seed_load),
    .i_seed  (i_seed),
    .i_step  (w_step),
    .o_value (w_value)
  );

  // A client granted last cycle still has req high; mask it so it is not granted twice.
  assign w_elig = i_req & ~r_gnt;
  assign w_rot  = (w_elig >> r_ptr) | (w_elig << (N_REQ - int'(r_ptr)));

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = PTR_W'(k);
      end
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win      = (w_sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(w_sum - (PTR_W+1)'(N_REQ))
                                                   : w_sum[PTR_W-1:0];
  assign w_ptr_next = (w_win == PTR_W'(N_REQ - 1)) ? '0 : w_win + PTR_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_fsm   <= WARM;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
    end else if (i_seed_load) begin
      r_fsm   <= WARM;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_fsm)
        WARM: begin
          r_gnt <= '0;
          if (r_cnt == CNT_W'(WARMUP - 1)) begin
            r_fsm   <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (w_found) begin
            r_gnt   <= N_REQ'(1) << w_win;
            r_rdata <= w_value;
            r_ptr   <= w_ptr_next;
          end else begin
            r_gnt <= '0;
          end
        end
        default: begin
          r_fsm <= WARM;
          r_gnt <= '0;
        end
      endcase
    end
  end

  assign o_gnt   = r_gnt;
  assign o_rdata = r_rdata;
  assign o_ready = r_ready;

endmodule

// File: tb/tb_meteor_rand_arbiter.sv
// tb/tb_meteor_rand_arbiter.sv - Directed and randomized checks of meteor_rand_arbiter against a behavioural model
module tb_meteor_rand_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_sl, a_ready;
  logic [15:0] a_seed;
  logic [3:0]  a_req, a_gnt;
  logic [9:0]  a_rdata;

  logic        b_rst, b_sl, b_ready;
  logic [15:0] b_seed;
  logic [3:0]  b_req, b_gnt;
  logic [15:0] b_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  bit do_cmp   = 1'b1;

  meteor_rand_arbiter #(.N_REQ(4), .LFSR_W(16), .OUT_W(10), .WARMUP(16)) u_dut_a (
    .i_clk       (clk),
    .i_reset     (a_rst),
    .i_seed_load (a_sl),
    .i_seed      (a_seed),
    .i_req       (a_req),
    .o_gnt       (a_gnt),
    .o_rdata     (a_rdata),
    .o_ready     (a_ready)
  );

  meteor_rand_arbiter #(.N_REQ(4), .LFSR_W(16), .OUT_W(16), .WARMUP(1)) u_dut_b (
    .i_clk       (clk),
    .i_reset     (b_rst),
    .i_seed_load (b_sl),
    .i_seed      (b_seed),
    .i_req       (b_req),
    .o_gnt       (b_gnt),
    .o_rdata     (b_rdata),
    .o_ready     (b_ready)
  );

  typedef struct {
    int lfsr;
    int warm_left;
    bit ready;
    int gnt;
    int rdata;
    int ptr;
  } model_t;

  model_t m_a, m_b;

  // x^16+x^5+x^3+x^2+1 as a parity over a tap mask.
  function automatic int lfsr_next(int l);
    int fb = $countones(l & 32'h2D) & 1;
    return (l >> 1) | (fb << 15);
  endfunction

  function automatic model_t model_next(model_t m, bit rst_n, bit sl, int seed, int req,
                                        int warmup, int out_w);
    model_t n = m;
    int elig;
    if (!rst_n) begin
      n.lfsr = 1; n.warm_left = warmup; n.ready = 1'b0; n.gnt = 0; n.rdata = 0; n.ptr = 0;
    end else if (sl) begin
      n.lfsr = (seed == 0) ? 1 : seed; n.warm_left = warmup; n.ready = 1'b0; n.gnt = 0;
    end else if (m.warm_left > 0) begin
      n.lfsr = lfsr_next(m.lfsr);
      n.warm_left = m.warm_left - 1;
      n.ready = (n.warm_left == 0);
      n.gnt = 0;
    end else begin
      elig = req & ~m.gnt & 15;
      n.gnt = 0;
      for (int k = 0; k < 4; k++) begin
        int idx = (m.ptr + k) % 4;
        if (n.gnt == 0 && elig[idx]) begin
          n.gnt   = 1 << idx;
          n.rdata = m.lfsr & ((1 << out_w) - 1);
          n.ptr   = (idx + 1) % 4;
        end
      end
      n.lfsr = lfsr_next(m.lfsr);
    end
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    m_a = model_next(m_a, a_rst, a_sl, a_seed, a_req, 16, 10);
    m_b = model_next(m_b, b_rst, b_sl, b_seed, b_req, 1, 16);
    #1;
    if (do_cmp) begin
      check_eq("a_gnt", a_gnt, m_a.gnt);
      check_eq("a_ready", a_ready, m_a.ready);
      check_eq("a_rdata", a_rdata, m_a.rdata);
      check_eq("a_onehot", $onehot0(a_gnt), 1);
      check_eq("b_gnt", b_gnt, m_b.gnt);
      check_eq("b_ready", b_ready, m_b.ready);
      check_eq("b_rdata", b_rdata, m_b.rdata);
      check_eq("b_onehot", $onehot0(b_gnt), 1);
      check_eq("b_state", u_dut_b.u_core.r_state, m_b.lfsr);
    end
  endtask

  initial begin
    int          first_ret;
    int          exp_l;
    logic [3:0]  prev;
    logic [15:0] s0 [8];
    logic [15:0] s1 [8];

    a_rst = 1'b0; a_sl = 1'b0; a_seed = '0; a_req = '0;
    b_rst = 1'b0; b_sl = 1'b0; b_seed = '0; b_req = '0;
    tick();
    tick();
    check_eq("rst_a_gnt", a_gnt, 0);
    check_eq("rst_a_ready", a_ready, 0);
    check_eq("rst_a_rdata", a_rdata, 0);
    check_eq("rst_b_rdata", b_rdata, 0);

    // Warm-up length after reset release
    a_rst = 1'b1; b_rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_eq("t1_ready", a_ready, (i >= 16) ? 1 : 0);
      check_eq("t1_gnt", a_gnt, 0);
    end

    // First values after seeding with 1
    b_seed = 16'h0001; b_sl = 1'b1; b_req = 4'b0011;
    tick();
    b_sl = 1'b0;
    tick();
    tick();
    check_eq("t2_gnt0", b_gnt, 4'b0001);
    check_eq("t2_rdata0", b_rdata, 16'h8000);
    tick();
    check_eq("t2_gnt1", b_gnt, 4'b0010);
    check_eq("t2_rdata1", b_rdata, 16'h4000);
    b_req = 4'b0000;

    // Round-robin order with every client requesting
    b_rst = 1'b0;
    tick();
    b_rst = 1'b1; b_req = 4'hF;
    tick();
    prev = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("t3_order", b_gnt, 1 << (i % 4));
      check_eq("t3_repeat", |(b_gnt & prev), 0);
      prev = b_gnt;
    end

    // Zero seed behaves like seed 1
    b_seed = 16'h0000; b_sl = 1'b1;
    tick();
    b_sl = 1'b0;
    check_eq("t4_guard", u_dut_b.u_core.r_state, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      s0[i] = b_rdata;
      check_eq("t4_nonzero", u_dut_b.u_core.r_state != 0, 1);
    end
    b_seed = 16'h0001; b_sl = 1'b1;
    tick();
    b_sl = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      s1[i] = b_rdata;
    end
    exp_l = 1;
    for (int i = 0; i < 8; i++) begin
      exp_l = lfsr_next(exp_l);
      check_eq("t4_seed0", s0[i], exp_l);
      check_eq("t4_seed1", s1[i], exp_l);
    end

    // Seed load and reset while a grant is on the wire
    check_eq("t5_pre", b_gnt != 0, 1);
    b_seed = 16'h1234; b_sl = 1'b1;
    tick();
    b_sl = 1'b0;
    check_eq("t5_sl_gnt", b_gnt, 0);
    check_eq("t5_sl_ready", b_ready, 0);
    tick();
    check_eq("t5_sl_warm", b_ready, 1);
    check_eq("t5_sl_gnt2", b_gnt, 0);
    tick();
    check_eq("t5_resume", b_gnt != 0, 1);
    b_rst = 1'b0;
    tick();
    b_rst = 1'b1;
    check_eq("t5_rst_gnt", b_gnt, 0);
    check_eq("t5_rst_ready", b_ready, 0);
    tick();
    tick();
    check_eq("t5_rst_first", b_gnt, 4'b0001);

    // Randomized traffic with occasional reseeding
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) a_req = 4'($urandom);
      if ($urandom_range(0, 2) == 0) b_req = 4'($urandom);
      a_sl   = ($urandom_range(0, 49) == 0);
      a_seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      b_sl   = ($urandom_range(0, 29) == 0);
      b_seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      tick();
    end
    a_sl = 1'b0; b_sl = 1'b0;

    // Full period from seed 1
    b_req = 4'b0001; b_seed = 16'h0001; b_sl = 1'b1;
    tick();
    b_sl = 1'b0;
    check_eq("t6_start", u_dut_b.u_core.r_state, 1);
    do_cmp = 1'b0;
    first_ret = 0;
    for (int s = 1; s <= 65535; s++) begin
      tick();
      if (first_ret == 0 && u_dut_b.u_core.r_state == 16'h0001) first_ret = s;
    end
    do_cmp = 1'b1;
    check_eq("t6_period", first_ret, 65535);
    check_eq("t6_model", u_dut_b.u_core.r_state, m_b.lfsr);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
